// File: rtl/blake2s_wb_bridge.sv
// Wishbone classic slave bridge onto the BLAKE2s core register bus: one core access per bus cycle,
// window/partial-write filtering with error ack, and a reset-deassertion synchronizer for the core.
module blake2s_wb_bridge #(
    parameter logic [7:0] BASE_ADDR = 8'h30,
    parameter int         READ_LAT  = 1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        core_reset_n_o,
    output logic        core_cs_o,
    output logic        core_we_o,
    output logic [7:0]  core_address_o,
    output logic [31:0] core_write_data_o,
    input  logic [31:0] core_read_data_i,
    output logic [7:0]  err_count_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_RWAIT,
        S_ACK,
        S_ERRACK
    } state_t;

    state_t      state;
    state_t      state_d;
    logic [1:0]  lat_cnt;
    logic [1:0]  lat_cnt_d;
    logic        we_q;
    logic        capture;
    logic        req;
    logic        reject;
    logic        rst_meta;

    // Only the window byte and the word index take part in decoding.
    logic unused_adr;
    assign unused_adr = ^{wbs_adr_i[23:10], wbs_adr_i[1:0]};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rst_meta       <= 1'b0;
            core_reset_n_o <= 1'b0;
        end else begin
            rst_meta       <= 1'b1;
            core_reset_n_o <= rst_meta;
        end
    end

    assign req    = wbs_cyc_i & wbs_stb_i & core_reset_n_o;
    assign reject = (wbs_adr_i[31:24] != BASE_ADDR) | (wbs_we_i & (wbs_sel_i != 4'hF));

    always_comb begin
        state_d   = state;
        lat_cnt_d = lat_cnt;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    state_d = reject ? S_ERRACK : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!wbs_cyc_i) begin
                    state_d = S_IDLE;
                end else if (we_q) begin
                    state_d = S_ACK;
                end else begin
                    state_d   = S_RWAIT;
                    lat_cnt_d = 2'(READ_LAT);
                end
            end
            S_RWAIT: begin
                // An abandoned read is dropped without touching the held read data.
                if (!wbs_cyc_i) begin
                    state_d = S_IDLE;
                end else if (lat_cnt == 2'd1) begin
                    capture = 1'b1;
                    state_d = S_ACK;
                end else begin
                    lat_cnt_d = lat_cnt - 2'd1;
                end
            end
            S_ACK:    state_d = S_IDLE;
            S_ERRACK: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state             <= S_IDLE;
            lat_cnt           <= 2'd0;
            we_q              <= 1'b0;
            wbs_ack_o         <= 1'b0;
            wbs_dat_o         <= 32'd0;
            core_cs_o         <= 1'b0;
            core_we_o         <= 1'b0;
            core_address_o    <= 8'd0;
            core_write_data_o <= 32'd0;
            err_count_o       <= 8'd0;
        end else begin
            state     <= state_d;
            lat_cnt   <= lat_cnt_d;
            // Outputs are decoded from the next state so they line up with it cycle for cycle.
            core_cs_o <= (state_d == S_ISSUE);
            core_we_o <= (state_d == S_ISSUE) & wbs_we_i;
            wbs_ack_o <= (state_d == S_ACK) | (state_d == S_ERRACK);
            if (state == S_IDLE && state_d == S_ISSUE) begin
                we_q              <= wbs_we_i;
                core_address_o    <= wbs_adr_i[9:2];
                core_write_data_o <= wbs_dat_i;
            end
            if (capture) begin
                wbs_dat_o <= core_read_data_i;
            end else if (state_d == S_ERRACK) begin
                wbs_dat_o <= 32'd0;
            end
            if (state_d == S_ERRACK && err_count_o != 8'hFF) begin
                err_count_o <= err_count_o + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_blake2s_wb_bridge.sv
// Randomized and directed bench for blake2s_wb_bridge against a transaction-level reference model.
module tb_blake2s_wb_bridge;

    localparam logic [7:0] BASE = 8'h30;
    localparam int         RL   = 1;

    logic        clk;
    logic        rst;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic        ack;
    logic [31:0] rdat;
    logic        core_reset_n;
    logic        core_cs;
    logic        core_we;
    logic [7:0]  core_addr;
    logic [31:0] core_wdat;
    logic [31:0] core_rdat;
    logic [7:0]  err_count;

    blake2s_wb_bridge #(.BASE_ADDR(BASE), .READ_LAT(RL)) dut (
        .wb_clk_i          (clk),
        .wb_rst_i          (rst),
        .wbs_cyc_i         (cyc),
        .wbs_stb_i         (stb),
        .wbs_we_i          (we),
        .wbs_sel_i         (sel),
        .wbs_adr_i         (adr),
        .wbs_dat_i         (wdat),
        .wbs_ack_o         (ack),
        .wbs_dat_o         (rdat),
        .core_reset_n_o    (core_reset_n),
        .core_cs_o         (core_cs),
        .core_we_o         (core_we),
        .core_address_o    (core_addr),
        .core_write_data_o (core_wdat),
        .core_read_data_i  (core_rdat),
        .err_count_o       (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [7:0] a);
        if (a == 8'h01) return 32'h626C_616B;
        return {a, ~a, a ^ 8'h5A, 8'h3C};
    endfunction

    // Core register file: written words override the power-up pattern; reads return after RL cycles.
    logic [31:0] core_mem [256];
    logic        written  [256];
    logic [31:0] rd_pipe  [RL];
    always @(posedge clk) begin
        if (core_cs && core_we) begin
            core_mem[core_addr] <= core_wdat;
            written[core_addr]  <= 1'b1;
        end
        if (core_cs && !core_we)
            rd_pipe[0] <= (written[core_addr] === 1'b1) ? core_mem[core_addr] : init_val(core_addr);
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign core_rdat = rd_pipe[RL-1];

    int          total = 0;
    int          bad   = 0;
    logic [31:0] ref_mem [256];
    logic [7:0]  exp_err;
    logic [31:0] last_dat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic        rej;
        int          ack_cyc;
        int          cs_n;
        int          exp_cyc;
        logic [7:0]  cs_a;
        logic        cs_we;
        logic [31:0] cs_d;
        logic [31:0] got_dat;
        logic [31:0] exp_dat;
        rej     = (a[31:24] != BASE) || (w && s != 4'hF);
        ack_cyc = 0;
        cs_n    = 0;
        cs_a    = 8'd0;
        cs_we   = 1'b0;
        cs_d    = 32'd0;
        got_dat = 32'd0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        for (int k = 1; k <= 20 && ack_cyc == 0; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (core_cs) begin
                cs_n++;
                cs_a  = core_addr;
                cs_we = core_we;
                cs_d  = core_wdat;
            end
            if (ack) begin
                ack_cyc = k;
                got_dat = rdat;
            end
        end
        cyc = 1'b0; stb = 1'b0;
        if (rej) begin
            exp_cyc  = 1;
            exp_dat  = 32'd0;
            last_dat = 32'd0;
            exp_err  = (exp_err == 8'hFF) ? 8'hFF : exp_err + 8'd1;
        end else if (w) begin
            exp_cyc = 2;
            ref_mem[a[9:2]] = d;
            exp_dat = last_dat;
        end else begin
            exp_cyc  = 2 + RL;
            exp_dat  = ref_mem[a[9:2]];
            last_dat = exp_dat;
        end
        chk("ack_cycle", 32'(ack_cyc), 32'(exp_cyc));
        chk("rd_data", got_dat, exp_dat);
        chk("cs_count", 32'(cs_n), rej ? 32'd0 : 32'd1);
        if (!rej) begin
            chk("cs_addr", {24'd0, cs_a}, {24'd0, a[9:2]});
            chk("cs_we", {31'd0, cs_we}, {31'd0, w});
            if (w) chk("cs_wdata", cs_d, d);
        end
        chk("err_count", {24'd0, err_count}, {24'd0, exp_err});
    endtask

    initial begin
        logic        rw;
        logic [7:0]  base;
        logic [7:0]  word;
        logic [3:0]  s;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
        exp_err  = 8'd0;
        last_dat = 32'd0;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'd0; wdat = 32'd0;
        #12;
        chk("rst_core_reset_n", {31'd0, core_reset_n}, 32'd0);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_cs", {31'd0, core_cs}, 32'd0);
        chk("rst_dat", rdat, 32'd0);
        chk("rst_err", {24'd0, err_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("core_reset_n_up", {31'd0, core_reset_n}, 32'd1);

        access(1'b1, 32'h3000_0020, 32'h0000_0001, 4'hF);
        access(1'b0, 32'h3000_0004, 32'd0, 4'hF);
        access(1'b0, 32'h2000_0000, 32'd0, 4'hF);
        access(1'b1, 32'h3000_0000, 32'hDEAD_BEEF, 4'h3);
        access(1'b0, 32'h3000_0020, 32'd0, 4'hF);

        for (int n = 0; n < 80; n++) begin
            rw   = 1'($urandom);
            base = ($urandom_range(0, 4) == 0) ? 8'($urandom) : BASE;
            word = 8'($urandom_range(0, 15));
            s    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            access(rw, {base, 14'($urandom), word, 2'($urandom)}, $urandom, s);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        for (int n = 0; n < 300; n++)
            access(1'($urandom), {8'h31, 24'($urandom)}, $urandom, 4'hF);
        chk("err_saturated", {24'd0, err_count}, 32'h0000_00FF);

        // Abandon a read while it waits for core data.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3000_0008;
        @(posedge clk); @(negedge clk);
        chk("abort_cs", {31'd0, core_cs}, 32'd1);
        @(posedge clk); @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); @(negedge clk);
            chk("abort_no_ack", {31'd0, ack}, 32'd0);
            chk("abort_dat_hold", rdat, last_dat);
        end
        access(1'b0, 32'h3000_000C, 32'd0, 4'hF);

        // Reset in the middle of a write, with the strobe held through release.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h3000_0040; wdat = 32'hA5A5_0F0F;
        @(posedge clk); #2;
        chk("issue_cs", {31'd0, core_cs}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_core_reset_n", {31'd0, core_reset_n}, 32'd0);
        chk("midrst_cs", {31'd0, core_cs}, 32'd0);
        chk("midrst_we", {31'd0, core_we}, 32'd0);
        chk("midrst_ack", {31'd0, ack}, 32'd0);
        chk("midrst_dat", rdat, 32'd0);
        chk("midrst_err", {24'd0, err_count}, 32'd0);
        chk("midrst_addr", {24'd0, core_addr}, 32'd0);
        chk("midrst_wdata", core_wdat, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_err  = 8'd0;
        last_dat = 32'd0;
        @(posedge clk); @(negedge clk);
        chk("rel1_core_reset_n", {31'd0, core_reset_n}, 32'd0);
        chk("rel1_cs", {31'd0, core_cs}, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("rel2_core_reset_n", {31'd0, core_reset_n}, 32'd1);
        chk("rel2_cs", {31'd0, core_cs}, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("rel3_cs", {31'd0, core_cs}, 32'd1);
        @(posedge clk); @(negedge clk);
        chk("rel4_ack", {31'd0, ack}, 32'd1);
        cyc = 1'b0; stb = 1'b0;
        ref_mem[8'h10] = 32'hA5A5_0F0F;
        access(1'b0, 32'h3000_0040, 32'd0, 4'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
